// File: rtl/gain_update_pkg.sv
// Shared constants, FSM encoding and address helper for the gain-update block.
// Also provides the base address of the four-word past_qua_en history in scratch memory.
package gain_update_pkg;

    localparam logic [11:0]        PAST_QUA_EN = 12'h3C0;
    localparam int                 EXP_BIAS    = 13;
    localparam int                 SHL_AMT     = 13;
    localparam logic signed [15:0] QUA_SCALE   = 16'sd24660;
    localparam logic signed [31:0] MAX_32      = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] MIN_32      = 32'sh8000_0000;
    localparam logic signed [15:0] MAX_16      = 16'sh7FFF;
    localparam logic signed [15:0] MIN_16      = 16'sh8000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_LOG_START,
        S_LOG_WAIT,
        S_COMP,
        S_SCALE,
        S_WRITE,
        S_FIN
    } state_e;

    function automatic logic [11:0] past_addr(input logic [1:0] idx);
        return {PAST_QUA_EN[11:2], idx};
    endfunction

endpackage

// File: rtl/gain_update_log2.sv
// log2_unit: two-stage Log2 (normalise, then 33-entry table interpolation).
// Fixed latency: done_o is high two cycles after start_i; inputs <= 0 give exp=0, frac=0.
module log2_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] l_x_i,
    output logic        done_o,
    output logic [15:0] exp_o,
    output logic [15:0] frac_o
);

    localparam logic [15:0] LOG_TAB [0:32] = '{
        16'd0,     16'd1455,  16'd2866,  16'd4236,  16'd5568,  16'd6863,  16'd8124,
        16'd9352,  16'd10549, 16'd11716, 16'd12855, 16'd13967, 16'd15054, 16'd16117,
        16'd17156, 16'd18172, 16'd19167, 16'd20142, 16'd21097, 16'd22033, 16'd22951,
        16'd23852, 16'd24735, 16'd25603, 16'd26455, 16'd27291, 16'd28113, 16'd28922,
        16'd29716, 16'd30497, 16'd31266, 16'd32023, 16'd32767
    };

    logic [4:0]  msb_pos;
    logic [19:0] x_mant;
    logic        valid_q;
    logic        zero_q;
    logic [4:0]  exp1_q;
    logic [19:0] mant_q;
    logic [15:0] tab_lo;
    logic [15:0] tab_hi;
    logic [31:0] interp;
    logic [15:0] frac_calc;

    // Exponent is the position of the leading one; mantissa keeps bits 29..10 after normalising.
    always_comb begin
        msb_pos = '0;
        for (int b = 0; b < 31; b++) begin
            if (l_x_i[b]) msb_pos = 5'(b);
        end
        x_mant = 20'((l_x_i << (5'd30 - msb_pos)) >> 10);
    end

    assign tab_lo    = LOG_TAB[{1'b0, mant_q[19:15]}];
    assign tab_hi    = LOG_TAB[{1'b0, mant_q[19:15]} + 6'd1];
    assign interp    = 32'(tab_hi - tab_lo) * 32'(mant_q[14:0]);
    assign frac_calc = 16'(({tab_lo, 16'h0000} + (interp << 1)) >> 16);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            exp1_q  <= '0;
            mant_q  <= '0;
            done_o  <= 1'b0;
            exp_o   <= '0;
            frac_o  <= '0;
        end else begin
            valid_q <= start_i;
            done_o  <= valid_q;
            if (start_i) begin
                zero_q <= l_x_i[31] || (l_x_i == 32'd0);
                exp1_q <= msb_pos;
                mant_q <= x_mant;
            end
            if (valid_q) begin
                exp_o  <= zero_q ? 16'd0 : {11'd0, exp1_q};
                frac_o <= zero_q ? 16'd0 : frac_calc;
            end
        end
    end

endmodule

// File: rtl/gain_update.sv
// gain_update: shifts the past_qua_en history in scratch memory and stores the new quantised energy.
// Optional qua_ener output enabled by GAIN_UPDATE_ENERGY_OUT_EN.
module gain_update
    import gain_update_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] L_gbk12,
    output logic        done,
    output logic [11:0] scratch_mem_read_addr,
    input  logic [31:0] scratch_mem_in,
    output logic [11:0] scratch_mem_write_addr,
    output logic [31:0] scratch_mem_out,
    output logic        scratch_mem_write_en
`ifdef GAIN_UPDATE_ENERGY_OUT_EN
    ,
    output logic [15:0] qua_ener
`endif
);

    state_e             state_q;
    logic [1:0]         i_q;
    logic [31:0]        l_gbk12_q;
    logic [15:0]        exp_q;
    logic [15:0]        frac_q;
    logic signed [31:0] acc_q;
    logic               done_q;
    logic [11:0]        rd_addr_q;
    logic [11:0]        wr_addr_q;
    logic               wr_en_q;
    logic [31:0]        wdata_q;
    logic               log_start_q;

    logic               log_done;
    logic [15:0]        log_exp;
    logic [15:0]        log_frac;
    logic [31:0]        exp_ext;
    logic signed [31:0] comp_val;
    logic signed [31:0] acc_shl;
    logic signed [31:0] tmp_ext;
    logic signed [31:0] prod_sh;
    logic signed [15:0] result;

    log2_unit u_log2 (
        .clk     (clk),
        .reset   (reset),
        .start_i (log_start_q),
        .l_x_i   (l_gbk12_q),
        .done_o  (log_done),
        .exp_o   (log_exp),
        .frac_o  (log_frac)
    );

    assign exp_ext  = {{16{exp_q[15]}}, exp_q};
    assign comp_val = ((exp_ext - 32'(EXP_BIAS)) << 16) + ({16'h0000, frac_q} << 1);

    // Saturating L_shl, extract_h, then saturating Q15 multiply by the energy scale.
    always_comb begin
        if (acc_q[31:31-SHL_AMT] == {(SHL_AMT + 1){acc_q[31]}}) begin
            acc_shl = acc_q <<< SHL_AMT;
        end else begin
            acc_shl = acc_q[31] ? MIN_32 : MAX_32;
        end
        tmp_ext = 32'(signed'(16'(acc_shl >>> 16)));
        prod_sh = (tmp_ext * 32'(QUA_SCALE)) >>> 15;
        if (prod_sh > 32'sd32767) begin
            result = MAX_16;
        end else if (prod_sh < -32'sd32768) begin
            result = MIN_16;
        end else begin
            result = prod_sh[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            l_gbk12_q   <= '0;
            exp_q       <= '0;
            frac_q      <= '0;
            acc_q       <= '0;
            done_q      <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wdata_q     <= '0;
            log_start_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wdata_q     <= '0;
            log_start_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        l_gbk12_q <= L_gbk12;
                        i_q       <= 2'd3;
                        rd_addr_q <= past_addr(2'd2);
                        state_q   <= S_RD;
                    end
                end
                S_RD: begin
                    // Read address stays up through WR, where the returned word is written back one slot up.
                    rd_addr_q <= rd_addr_q;
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= past_addr(i_q);
                    state_q   <= S_WR;
                end
                S_WR: begin
                    i_q <= i_q - 2'd1;
                    if (i_q == 2'd1) begin
                        log_start_q <= 1'b1;
                        state_q     <= S_LOG_START;
                    end else begin
                        rd_addr_q <= past_addr(i_q - 2'd2);
                        state_q   <= S_RD;
                    end
                end
                S_LOG_START: state_q <= S_LOG_WAIT;
                S_LOG_WAIT: begin
                    if (log_done) begin
                        exp_q   <= log_exp;
                        frac_q  <= log_frac;
                        state_q <= S_COMP;
                    end
                end
                S_COMP: begin
                    acc_q   <= comp_val;
                    state_q <= S_SCALE;
                end
                S_SCALE: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= past_addr(2'd0);
                    wdata_q   <= {{16{result[15]}}, result};
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= S_FIN;
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done                   = done_q;
    assign scratch_mem_read_addr  = rd_addr_q;
    assign scratch_mem_write_addr = wr_addr_q;
    assign scratch_mem_write_en   = wr_en_q;
    assign scratch_mem_out        = (state_q == S_WR) ? scratch_mem_in : wdata_q;

`ifdef GAIN_UPDATE_ENERGY_OUT_EN
    logic [15:0] qua_ener_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qua_ener_q <= '0;
        end else if (state_q == S_WRITE) begin
            qua_ener_q <= wdata_q[15:0];
        end
    end

    assign qua_ener = qua_ener_q;
`endif

endmodule

// File: tb/tb_gain_update.sv
// Directed bench for gain_update with a four-word scratch-memory model at PAST_QUA_EN.
// Checks qua_ener as well when GAIN_UPDATE_ENERGY_OUT_EN is defined.
module tb_gain_update;
    import gain_update_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] L_gbk12 = '0;
    logic        done;
    logic [11:0] scratch_mem_read_addr;
    logic [31:0] scratch_mem_in;
    logic [11:0] scratch_mem_write_addr;
    logic [31:0] scratch_mem_out;
    logic        scratch_mem_write_en;
`ifdef GAIN_UPDATE_ENERGY_OUT_EN
    logic [15:0] qua_ener;
`endif

    always #5 clk = ~clk;

    gain_update dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .L_gbk12                (L_gbk12),
        .done                   (done),
        .scratch_mem_read_addr  (scratch_mem_read_addr),
        .scratch_mem_in         (scratch_mem_in),
        .scratch_mem_write_addr (scratch_mem_write_addr),
        .scratch_mem_out        (scratch_mem_out),
        .scratch_mem_write_en   (scratch_mem_write_en)
`ifdef GAIN_UPDATE_ENERGY_OUT_EN
        ,
        .qua_ener               (qua_ener)
`endif
    );

    logic [9:0]  base_hi;
    logic [31:0] mem [0:3];
    logic [31:0] rd_data = '0;
    logic        pl_en = 1'b0;
    logic [1:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    int          stray_wr = 0;

    assign base_hi        = PAST_QUA_EN[11:2];
    assign scratch_mem_in = rd_data;

    always @(posedge clk) begin
        if (scratch_mem_read_addr[11:2] == base_hi) rd_data <= mem[scratch_mem_read_addr[1:0]];
        else                                        rd_data <= 32'hDEAD_BEEF;
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (scratch_mem_write_en) begin
            if (scratch_mem_write_addr[11:2] == base_hi) mem[scratch_mem_write_addr[1:0]] <= scratch_mem_out;
            else                                         stray_wr <= stray_wr + 1;
        end
    end

    int done_cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (scratch_mem_write_en) wr_cnt <= wr_cnt + 1;
        if (scratch_mem_read_addr != 12'd0 && !scratch_mem_write_en) rd_cnt <= rd_cnt + 1;
        if (scratch_mem_read_addr != 12'd0 && scratch_mem_write_addr != 12'd0 && !scratch_mem_write_en)
            overlap_cnt <= overlap_cnt + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic preload(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] vals [0:3];
        vals[0] = w0; vals[1] = w1; vals[2] = w2; vals[3] = w3;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            pl_en = 1'b1; pl_idx = 2'(k); pl_data = vals[k];
        end
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic run_update(input logic [31:0] l, output int lat);
        int  d0;
        int  w0;
        int  r0;
        bit  seen;
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b1; L_gbk12 = l;
        @(posedge clk); #1;
        start = 1'b0; L_gbk12 = 32'h0BAD_0BAD;
        lat = 1; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else      lat++;
        end
        check("done_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("writes", 32'(wr_cnt - w0), 32'd4);
        check("reads", 32'(rd_cnt - r0), 32'd3);
        $display("update L=%h -> mem %h %h %h %h latency=%0d", l, mem[0], mem[1], mem[2], mem[3], lat);
    endtask

    int lat_ref;
    int lat;
    int d0;
    int w0;
    int r0;
    int dd;
    bit ok;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(scratch_mem_write_en), 32'd0);
        check("rst_raddr", 32'(scratch_mem_read_addr), 32'd0);
        check("rst_waddr", 32'(scratch_mem_write_addr), 32'd0);
        check("rst_wdata", scratch_mem_out, 32'd0);
`ifdef GAIN_UPDATE_ENERGY_OUT_EN
        check("rst_qua_ener", 32'(qua_ener), 32'd0);
`endif
        reset = 1'b1;

        preload(32'd1, 32'd2, 32'd3, 32'd4);
        run_update(32'h0000_2000, lat_ref);
        check("g2000_w0", mem[0], 32'd0);
        check("g2000_w1", mem[1], 32'd1);
        check("g2000_w2", mem[2], 32'd2);
        check("g2000_w3", mem[3], 32'd3);

        run_update(32'h0000_4000, lat);
        check("g4000_w0", mem[0], 32'h0000_1815);
        check("g4000_w1", mem[1], 32'd0);
        check("g4000_w3", mem[3], 32'd2);
        check("latency_fixed", 32'(lat), 32'(lat_ref));
`ifdef GAIN_UPDATE_ENERGY_OUT_EN
        check("qua_ener_load", 32'(qua_ener), 32'd6165);
        repeat (6) @(posedge clk);
        #1;
        check("qua_ener_hold", 32'(qua_ener), 32'd6165);
`endif

        run_update(32'h0000_0000, lat);
        check("gzero_w0", mem[0], 32'hFFFF_9FAC);
        check("gzero_w1", mem[1], 32'h0000_1815);
        check("latency_zero", 32'(lat), 32'(lat_ref));

        run_update(32'hFFFF_FFFF, lat);
        check("gneg_w0", mem[0], 32'hFFFF_9FAC);
        check("gneg_w1", mem[1], 32'hFFFF_9FAC);

        run_update(32'h0000_6000, lat);
        check("g6000_w0", mem[0], 32'h0000_262A);

        run_update(32'h7FFF_FFFF, lat);
        check("gmax_w0", mem[0], 32'h0000_6053);
        check("gmax_w1", mem[1], 32'h0000_262A);
`ifdef GAIN_UPDATE_ENERGY_OUT_EN
        check("qua_ener_max", 32'(qua_ener), 32'h0000_6053);
`endif

        // start held high for 40 cycles: every accepted request must run to completion
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        @(posedge clk); #1;
        start = 1'b1; L_gbk12 = 32'h0000_4000;
        repeat (40) @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        dd = done_cnt - d0;
        $display("hold start: updates=%0d writes=%0d reads=%0d", dd, wr_cnt - w0, rd_cnt - r0);
        ok = (dd >= 2);
        check("hold_updates", 32'(ok), 32'd1);
        check("hold_writes", 32'(wr_cnt - w0), 32'(4 * dd));
        check("hold_reads", 32'(rd_cnt - r0), 32'(3 * dd));
        check("hold_w0", mem[0], 32'h0000_1815);

        // reset after the second shift write
        preload(32'd10, 32'd20, 32'd30, 32'd40);
        d0 = done_cnt; w0 = wr_cnt;
        @(posedge clk); #1;
        start = 1'b1; L_gbk12 = 32'h0000_4000;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (wr_cnt - w0 == 2) ok = 1'b1;
        end
        check("abort_reach_wr2", 32'(ok), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_we", 32'(scratch_mem_write_en), 32'd0);
        check("abort_raddr", 32'(scratch_mem_read_addr), 32'd0);
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        $display("abort: mem %h %h %h %h writes=%0d", mem[0], mem[1], mem[2], mem[3], wr_cnt - w0);
        check("abort_w3", mem[3], 32'd30);
        check("abort_w2", mem[2], 32'd20);
        check("abort_w1", mem[1], 32'd20);
        check("abort_w0", mem[0], 32'd10);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_writes", 32'(wr_cnt - w0), 32'd2);

        run_update(32'h0000_2000, lat);
        check("post_abort_w0", mem[0], 32'd0);
        check("post_abort_w1", mem[1], 32'd10);
        check("post_abort_w3", mem[3], 32'd20);

        check("stray_writes", 32'(stray_wr), 32'd0);
        check("addr_overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gain_update.md
GAIN_UPDATE -- requirements
Module: gain_update

Interface
REQ-001 Parameter: none; the scratch-memory base address is constant PAST_QUA_EN from the shared parameter list.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 L_gbk12  input  32  summed codebook gain (gbk1+gbk2), Q13, sampled when start is accepted.
REQ-006 done  output  1  one-cycle pulse when past_qua_en[0] has been written.
REQ-007 scratch_mem_read_addr  output  12  read address; read data is valid on scratch_mem_in the next cycle.
REQ-008 scratch_mem_in  input  32  read data.
REQ-009 scratch_mem_write_addr  output  12  write address.
REQ-010 scratch_mem_out  output  32  write data; 16-bit value sign-extended to 32 bits.
REQ-011 scratch_mem_write_en  output  1  write strobe, one cycle per word.

Function
REQ-012 Operation: shift past_qua_en[3..1] = past_qua_en[2..0], then past_qua_en[0] = mult(extract_h(L_shl(L_Comp(exp-13, frac), 13)), 24660), where (exp, frac) = Log2(L_gbk12).
REQ-013 States: IDLE, RD, WR, LOG_START, LOG_WAIT, COMP, SCALE, WRITE, FIN.
REQ-014 IDLE->RD on start; latch L_gbk12; set i=3.
REQ-015 RD: read {PAST_QUA_EN[11:2], (i-1)[1:0]}; go to WR.
REQ-016 WR: write scratch_mem_in to {PAST_QUA_EN[11:2], i[1:0]}; decrement i; if i becomes 0, go to LOG_START, otherwise go to RD.
REQ-017 LOG_START: pulse the log2_unit start for one cycle.
REQ-018 LOG_WAIT: wait for the log2_unit done, then capture exp[15:0] and frac[15:0].
REQ-019 COMP: L_acc = ((exp-13) << 16) + (frac << 1), using 32-bit two's-complement arithmetic.
REQ-020 SCALE: compute L_shl(L_acc, 13) with saturation to 0x7FFFFFFF/0x80000000, take the high 16 bits as tmp, then compute mult(tmp, 24660) = (tmp*24660) >>> 15 with saturation to 16 bits.
REQ-021 WRITE: write the result, sign-extended, to {PAST_QUA_EN[11:2], 2'b00}; assert done on the next cycle (FIN); then return to IDLE.
REQ-022 Log2 of L_gbk12 <= 0 shall yield exp=0 and frac=0.
REQ-023 start asserted outside IDLE shall be ignored.
REQ-024 Memory traffic shall be exactly 3 reads, then 4 writes; the only cycles with both read and write addresses driven are in WR.
REQ-025 Latency from start to done shall be fixed: 8 cycles plus the log2_unit latency.
REQ-026 All outputs other than registered state shall default to 0 in every state that does not drive them.

Reset
REQ-027 On reset low: state=IDLE, done=0, i=0, all datapath registers=0, write_en=0, all addresses=0.
REQ-028 Reset mid-operation shall abort immediately; any words already shifted remain in memory and no further write occurs.

Configuration
REQ-029 Macro GAIN_UPDATE_ENERGY_OUT_EN defined: add output qua_ener[15:0], which is registered and loaded in WRITE with the same value written to past_qua_en[0], and holds that value until the next WRITE or reset (reset value 0).
REQ-030 GAIN_UPDATE_ENERGY_OUT_EN undefined: no qua_ener port and no register; all other behaviour is identical.

Structure
REQ-031 PAST_QUA_EN and the constants 13, 24660 and the saturation limits shall reside in the shared parameter list.
REQ-032 Log2 shall be a separate sub-module, log2_unit (start/done handshake, L_norm plus the 33-entry log table ROM with interpolation), instanced once.
REQ-033 Saturating shift and multiply shall be implemented inline; the block shall have no external operator ports.

Verification
REQ-034 Preload past_qua_en={1,2,3,4}; L_gbk12=0x00002000 -> memory={0,1,2,3}; done pulses exactly once.
REQ-035 L_gbk12=0x00004000 -> past_qua_en[0]=6165 (word 0x00001815).
REQ-036 L_gbk12=0 -> L_shl saturates to 0x80000000, tmp=-32768, past_qua_en[0]=-24660 (word 0xFFFF9FAC).
REQ-037 start held high continuously for 40 cycles -> exactly one update per IDLE visit; no start accepted while busy.
REQ-038 Assert reset after the second WR write -> past_qua_en[3..2] already shifted, words [1..0] unchanged, done never pulses, state=IDLE.
REQ-039 With GAIN_UPDATE_ENERGY_OUT_EN defined, rerun REQ-035 -> qua_ener=6165 after WRITE and held until the next update.
